// File: rtl/rs_pkg.sv
// Op encodings and shared constants for the reservation
// station and its integer ALU.
package rs_pkg;
  localparam int ROB_TAG_W_DEF = 4;
  localparam logic [31:0] LINK_N = 32'd4;
  localparam logic [31:0] LINK_C = 32'd2;

  localparam logic [5:0] OP_LUI   = 6'd0;
  localparam logic [5:0] OP_AUIPC = 6'd1;
  localparam logic [5:0] OP_JAL   = 6'd2;
  localparam logic [5:0] OP_JALR  = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLT   = 6'd6;
  localparam logic [5:0] OP_BGE   = 6'd7;
  localparam logic [5:0] OP_BLTU  = 6'd8;
  localparam logic [5:0] OP_BGEU  = 6'd9;
  // 10..17 are memory ops owned by the LSB
  localparam logic [5:0] OP_ADDI  = 6'd18;
  localparam logic [5:0] OP_SLTI  = 6'd19;
  localparam logic [5:0] OP_SLTIU = 6'd20;
  localparam logic [5:0] OP_XORI  = 6'd21;
  localparam logic [5:0] OP_ORI   = 6'd22;
  localparam logic [5:0] OP_ANDI  = 6'd23;
  localparam logic [5:0] OP_SLLI  = 6'd24;
  localparam logic [5:0] OP_SRLI  = 6'd25;
  localparam logic [5:0] OP_SRAI  = 6'd26;
  localparam logic [5:0] OP_ADD   = 6'd27;
  localparam logic [5:0] OP_SUB   = 6'd28;
  localparam logic [5:0] OP_SLL   = 6'd29;
  localparam logic [5:0] OP_SLT   = 6'd30;
  localparam logic [5:0] OP_SLTU  = 6'd31;
  localparam logic [5:0] OP_XOR   = 6'd32;
  localparam logic [5:0] OP_SRL   = 6'd33;
  localparam logic [5:0] OP_SRA   = 6'd34;
  localparam logic [5:0] OP_OR    = 6'd35;
  localparam logic [5:0] OP_AND   = 6'd36;

  function automatic logic [31:0] link_addr(
    input logic [31:0] pc,
    input logic        is_c
  );
    return pc + (is_c ? LINK_C : LINK_N);
  endfunction
endpackage

// File: rtl/rs_alu.sv
// Combinational integer ALU: result value plus jalr target.
// Unknown ops produce zero.
module rs_alu
  import rs_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] vj,
  input  logic [31:0] vk,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic        is_c,
  output logic [31:0] result,
  output logic [31:0] jalr_pc
);
  logic [4:0] shi;
  logic [4:0] shr;

  assign shi = imm[4:0];
  assign shr = vk[4:0];
  assign jalr_pc = (vj + imm) & ~32'd1;

  always_comb begin
    result = '0;
    case (op)
      OP_LUI, OP_AUIPC: result = imm;
      OP_JAL, OP_JALR:  result = link_addr(pc, is_c);
      OP_BEQ:   result = {31'd0, vj == vk};
      OP_BNE:   result = {31'd0, vj != vk};
      OP_BLT:   result = {31'd0, $signed(vj) < $signed(vk)};
      OP_BGE:   result = {31'd0, $signed(vj) >= $signed(vk)};
      OP_BLTU:  result = {31'd0, vj < vk};
      OP_BGEU:  result = {31'd0, vj >= vk};
      OP_ADDI:  result = vj + imm;
      OP_SLTI:  result = {31'd0, $signed(vj) < $signed(imm)};
      OP_SLTIU: result = {31'd0, vj < imm};
      OP_XORI:  result = vj ^ imm;
      OP_ORI:   result = vj | imm;
      OP_ANDI:  result = vj & imm;
      OP_SLLI:  result = vj << shi;
      OP_SRLI:  result = vj >> shi;
      OP_SRAI:  result = $signed(vj) >>> shi;
      OP_ADD:   result = vj + vk;
      OP_SUB:   result = vj - vk;
      OP_SLL:   result = vj << shr;
      OP_SLT:   result = {31'd0, $signed(vj) < $signed(vk)};
      OP_SLTU:  result = {31'd0, vj < vk};
      OP_XOR:   result = vj ^ vk;
      OP_SRL:   result = vj >> shr;
      OP_SRA:   result = $signed(vj) >>> shr;
      OP_OR:    result = vj | vk;
      OP_AND:   result = vj & vk;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/rs_age_multi_cdb.sv
// Age-ordered ALU reservation station with multi-port wakeup.
// RS_DISPATCH_BYPASS_EN: ready dispatch issues at once when idle.
module rs_age_multi_cdb
  import rs_pkg::*;
#(
  parameter int RS_DEPTH  = 16,
  parameter int ROB_TAG_W = ROB_TAG_W_DEF,
  parameter int N_EXT     = 2,
  localparam int AGE_W = $clog2(RS_DEPTH),
  localparam int CNT_W = $clog2(RS_DEPTH) + 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  output logic                   rs_full,
  output logic [CNT_W-1:0]       rs_count,
  input  logic                   to_rs,
  input  logic [5:0]             op_type,
  input  logic                   j_in,
  input  logic                   k_in,
  input  logic [31:0]            vj_in,
  input  logic [31:0]            vk_in,
  input  logic [ROB_TAG_W-1:0]   qj_in,
  input  logic [ROB_TAG_W-1:0]   qk_in,
  input  logic [ROB_TAG_W-1:0]   dest_in,
  input  logic [31:0]            imm_in,
  input  logic [31:0]            inst_pc,
  input  logic                   is_c_inst,
  input  logic                   clear_all,
  input  logic [N_EXT-1:0]       ext_valid,
  input  logic [N_EXT*ROB_TAG_W-1:0] ext_tag,
  input  logic [N_EXT*32-1:0]    ext_value,
  output logic                   rs_to_rob,
  output logic [31:0]            value,
  output logic [ROB_TAG_W-1:0]   dest_out,
  output logic [31:0]            new_PC
);
  logic [RS_DEPTH-1:0]  busy, rj, rk;
  logic [31:0]          e_vj [RS_DEPTH];
  logic [31:0]          e_vk [RS_DEPTH];
  logic [31:0]          e_imm [RS_DEPTH];
  logic [31:0]          e_pc [RS_DEPTH];
  logic [ROB_TAG_W-1:0] e_qj [RS_DEPTH];
  logic [ROB_TAG_W-1:0] e_qk [RS_DEPTH];
  logic [ROB_TAG_W-1:0] e_dest [RS_DEPTH];
  logic [5:0]           e_op [RS_DEPTH];
  logic [RS_DEPTH-1:0]  e_c;
  logic [AGE_W-1:0]     e_age [RS_DEPTH];
  logic [CNT_W-1:0]     size;

  logic             found, accept, bypass, res_valid;
  logic [AGE_W-1:0] sel, fidx, best;
  logic [31:0]      alu_e, npc_e, res_value, res_npc;
  logic [ROB_TAG_W-1:0] res_tag;
  logic [32:0]      wi_j, wi_k;
  logic [32:0]      wj [RS_DEPTH];
  logic [32:0]      wk [RS_DEPTH];

  assign rs_count = size;
  assign rs_full  = (size == CNT_W'(RS_DEPTH));

  // later sources overwrite earlier ones: internal wins, then port 0
  function automatic logic [32:0] wake(
    input logic                 rdy,
    input logic [31:0]          v,
    input logic [ROB_TAG_W-1:0] q,
    input logic                 iv,
    input logic [ROB_TAG_W-1:0] it,
    input logic [31:0]          ival
  );
    logic [32:0] r;
    r = {rdy, v};
    if (!rdy) begin
      for (int p = N_EXT - 1; p >= 0; p--)
        if (ext_valid[p] &&
            ext_tag[p*ROB_TAG_W +: ROB_TAG_W] == q)
          r = {1'b1, ext_value[p*32 +: 32]};
      if (iv && it == q)
        r = {1'b1, ival};
    end
    return r;
  endfunction

  always_comb begin
    found = 1'b0;
    sel   = '0;
    best  = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (busy[i] && rj[i] && rk[i] &&
          (!found || e_age[i] > best)) begin
        found = 1'b1;
        sel   = AGE_W'(i);
        best  = e_age[i];
      end
  end

  always_comb begin
    fidx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!busy[i]) fidx = AGE_W'(i);
  end

  rs_alu u_alu_e (
    .op      (e_op[sel]),
    .vj      (e_vj[sel]),
    .vk      (e_vk[sel]),
    .imm     (e_imm[sel]),
    .pc      (e_pc[sel]),
    .is_c    (e_c[sel]),
    .result  (alu_e),
    .jalr_pc (npc_e)
  );

  assign wi_j = wake(j_in, vj_in, qj_in,
                     found, e_dest[sel], alu_e);
  assign wi_k = wake(k_in, vk_in, qk_in,
                     found, e_dest[sel], alu_e);

`ifdef RS_DISPATCH_BYPASS_EN
  logic [31:0] alu_b, npc_b;

  rs_alu u_alu_b (
    .op      (op_type),
    .vj      (wi_j[31:0]),
    .vk      (wi_k[31:0]),
    .imm     (imm_in),
    .pc      (inst_pc),
    .is_c    (is_c_inst),
    .result  (alu_b),
    .jalr_pc (npc_b)
  );

  assign bypass = to_rs && !rs_full && !found &&
                  wi_j[32] && wi_k[32];
  assign res_value = found ? alu_e : alu_b;
  assign res_npc   = found ? npc_e : npc_b;
  assign res_tag   = found ? e_dest[sel] : dest_in;
`else
  assign bypass    = 1'b0;
  assign res_value = alu_e;
  assign res_npc   = npc_e;
  assign res_tag   = e_dest[sel];
`endif

  assign res_valid = found || bypass;
  assign accept    = to_rs && !rs_full && !bypass;

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      wj[i] = wake(rj[i], e_vj[i], e_qj[i],
                   res_valid, res_tag, res_value);
      wk[i] = wake(rk[i], e_vk[i], e_qk[i],
                   res_valid, res_tag, res_value);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy      <= '0;
      size      <= '0;
      rs_to_rob <= 1'b0;
      value     <= '0;
      dest_out  <= '0;
      new_PC    <= '0;
      for (int i = 0; i < RS_DEPTH; i++)
        e_age[i] <= '0;
    end else if (rdy_in) begin
      if (clear_all) begin
        busy      <= '0;
        size      <= '0;
        rs_to_rob <= 1'b0;
      end else begin
        rs_to_rob <= res_valid;
        if (res_valid) begin
          value    <= res_value;
          dest_out <= res_tag;
          new_PC   <= res_npc;
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
          rj[i]   <= wj[i][32];
          e_vj[i] <= wj[i][31:0];
          rk[i]   <= wk[i][32];
          e_vk[i] <= wk[i][31:0];
          if (accept && busy[i] &&
              e_age[i] != AGE_W'(RS_DEPTH - 1))
            e_age[i] <= e_age[i] + 1'b1;
        end
        if (found) busy[sel] <= 1'b0;
        if (accept) begin
          busy[fidx]   <= 1'b1;
          rj[fidx]     <= wi_j[32];
          e_vj[fidx]   <= wi_j[31:0];
          rk[fidx]     <= wi_k[32];
          e_vk[fidx]   <= wi_k[31:0];
          e_qj[fidx]   <= qj_in;
          e_qk[fidx]   <= qk_in;
          e_dest[fidx] <= dest_in;
          e_imm[fidx]  <= imm_in;
          e_pc[fidx]   <= inst_pc;
          e_op[fidx]   <= op_type;
          e_c[fidx]    <= is_c_inst;
          e_age[fidx]  <= '0;
        end
        size <= size + CNT_W'(accept) - CNT_W'(found);
      end
    end
  end

  a_no_full_dispatch: assert property (
    @(posedge clk_in) disable iff (rst_in)
    !(rdy_in && to_rs && rs_full));
endmodule
